// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler in front of a 1-to-NUM_OUT demux.
// One word is held in an output register; sel drives the demux select.
module demux_rr_scheduler #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_OUT = 2,
    parameter int unsigned SEL_W   = 1,
    parameter int unsigned BURST   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_OUT-1:0] chan_en,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               held_q, held_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SEL_W-1:0]   sel_q, sel_d;

    logic               chan_ok;
    logic               out_fire;
    logic               accept;
    logic [SEL_W-1:0]   next_ptr;

    // Next enabled channel after cur, wrapping; may return cur itself.
    function automatic logic [SEL_W-1:0] next_enabled(
        input logic [SEL_W-1:0]   cur,
        input logic [NUM_OUT-1:0] mask
    );
        logic [SEL_W-1:0] c;
        logic [SEL_W-1:0] res;
        logic             found;
        c     = cur;
        res   = cur;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            c = (c == SEL_LAST) ? '0 : c + 1'b1;
            if (!found && mask[c]) begin
                res   = c;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        data_d   = data_q;
        sel_d    = sel_q;

        next_ptr = next_enabled(ptr_q, chan_en);
        // Mid-burst the channel mask is ignored so a burst always completes.
        chan_ok  = (state_q == ST_BURST) | chan_en[ptr_q];
        out_fire = held_q & out_ready[sel_q];
        in_ready = ~rst & en & chan_ok & (~held_q | out_ready[sel_q]);
        accept   = in_valid & in_ready;

        if (out_fire) begin
            held_d = 1'b0;
        end

        if (accept) begin
            held_d = 1'b1;
            data_d = in_data;
            sel_d  = ptr_q;
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                ptr_d   = next_ptr;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_BURST;
            end
        end else if (en && (state_q == ST_IDLE) && !chan_en[ptr_q] && (chan_en != '0)) begin
            ptr_d = next_ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        out_valid = '0;
        if (held_q) begin
            out_valid[sel_q] = 1'b1;
        end
    end

    assign out_data = data_q;
    assign sel      = sel_q;
    assign busy     = held_q | (state_q == ST_BURST);

endmodule
